// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/subtract pipeline: flag indices,
// unpacked-operand record and canonical quiet-NaN builder (fields sized for up to EXP_MAX/MAN_MAX).
package fpu_pkg;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX  = 0;

  localparam int EXP_MAX = 15;
  localparam int MAN_MAX = 63;
  localparam int W_MAX   = 1 + EXP_MAX + MAN_MAX;

  typedef struct packed {
    logic               sign;
    logic [EXP_MAX-1:0] exp;
    logic [MAN_MAX-1:0] man;
    logic               is_zero;
    logic               is_inf;
    logic               is_nan;
    logic               is_snan;
  } fp_unpacked_t;

  // Exponent/mantissa arrive zero-extended; exp_w/man_w give the live field widths.
  function automatic fp_unpacked_t fp_unpack(input logic sign, input logic [EXP_MAX-1:0] exp,
                                             input logic [MAN_MAX-1:0] man,
                                             input int exp_w, input int man_w);
    fp_unpacked_t       u;
    logic [EXP_MAX-1:0] ones;
    ones      = ~({EXP_MAX{1'b1}} << exp_w);
    u.sign    = sign;
    u.exp     = exp;
    u.man     = man;
    u.is_zero = (exp == '0);
    u.is_inf  = (exp == ones) && (man == '0);
    u.is_nan  = (exp == ones) && (man != '0);
    u.is_snan = u.is_nan && ((man & (MAN_MAX'(1) << (man_w - 1))) == '0);
    return u;
  endfunction

  function automatic logic [W_MAX-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [W_MAX-1:0] r;
    r = ~({W_MAX{1'b1}} << exp_w);
    r = r << man_w;
    r = r | (W_MAX'(1) << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module fpu_lzc #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Pipelined FP add/subtract, RNE, FTZ: 4 cycles input-to-result, 1 op/cycle.
// Single advance enable freezes all stages while the result is held unaccepted.
module fpu_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int XW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam int CW = $clog2(SW + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [W-1:0]         QNAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic [3:0]   v_q;
  logic         adv;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;

  fp_unpacked_t ua, ub;
  logic               swap;
  logic               s1_sign_d, s1_sub_d, s1_sign_q, s1_sub_q;
  logic [EXP_W-1:0]   s1_exp_d, s1_diff_d, s1_exp_q, s1_diff_q;
  logic [MAN_W:0]     s1_man_l_d, s1_man_s_d, s1_man_l_q, s1_man_s_q;
  logic [W+1:0]       s1_spc_d, s1_spc_q, s2_spc_q, s3_spc_q;
  logic               s2_sign_q, s2_sub_q, s3_sign_q, s3_sub_q;
  logic [EXP_W-1:0]   s2_exp_q, s3_exp_q;
  logic [XW-1:0]      s2_man_s_d, s2_man_l_q, s2_man_s_q, lost_mask;
  logic [SW-1:0]      s3_sum_d, s3_sum_q;
  logic [CW-1:0]      s3_lz_d, s3_lz_q;
  logic [XW-1:0]      norm;
  logic signed [EW-1:0] e_n, e_r;
  logic [MAN_W+1:0]   rnd;
  logic [MAN_W-1:0]   man_r;

  assign adv       = !v_q[3] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[3];
  assign result    = result_q;
  assign flags     = flags_q;

  // S1: unpack with denormals flushed, order operands so the larger magnitude leads.
  always_comb begin
    ua = fp_unpack(din1[W-1], EXP_MAX'(din1[W-2:MAN_W]), MAN_MAX'(din1[MAN_W-1:0]), EXP_W, MAN_W);
    ub = fp_unpack(din2[W-1] ^ op, EXP_MAX'(din2[W-2:MAN_W]), MAN_MAX'(din2[MAN_W-1:0]), EXP_W, MAN_W);
    swap       = {ub.exp, ub.man} > {ua.exp, ua.man};
    s1_sign_d  = swap ? ub.sign : ua.sign;
    s1_sub_d   = ua.sign ^ ub.sign;
    s1_exp_d   = EXP_W'(swap ? ub.exp : ua.exp);
    s1_diff_d  = EXP_W'(swap ? ub.exp - ua.exp : ua.exp - ub.exp);
    s1_man_l_d = (swap ? ub.is_zero : ua.is_zero) ? '0 : {1'b1, MAN_W'(swap ? ub.man : ua.man)};
    s1_man_s_d = (swap ? ua.is_zero : ub.is_zero) ? '0 : {1'b1, MAN_W'(swap ? ua.man : ub.man)};
    s1_spc_d   = '0;
    if (ua.is_nan || ub.is_nan)
      s1_spc_d = {1'b1, ua.is_snan | ub.is_snan, QNAN};
    else if (ua.is_inf && ub.is_inf && s1_sub_d)
      s1_spc_d = {2'b11, QNAN};
    else if (ua.is_inf || ub.is_inf)
      s1_spc_d = {2'b10, ua.is_inf ? ua.sign : ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // S2: align the smaller operand, folding every shifted-out bit into sticky.
  always_comb begin
    lost_mask = ~({XW{1'b1}} << s1_diff_q);
    if (int'(s1_diff_q) >= MAN_W + 3)
      s2_man_s_d = XW'(|s1_man_s_q);
    else
      s2_man_s_d = ({s1_man_s_q, 3'b000} >> s1_diff_q) | XW'(|({s1_man_s_q, 3'b000} & lost_mask));
  end

  // S3: magnitude add/subtract (never negative thanks to the S1 ordering).
  assign s3_sum_d = s2_sub_q ? ({1'b0, s2_man_l_q} - {1'b0, s2_man_s_q})
                             : ({1'b0, s2_man_l_q} + {1'b0, s2_man_s_q});

  fpu_lzc #(.WIDTH(SW), .CW(CW)) u_lzc (
    .data_i  (s3_sum_d),
    .count_o (s3_lz_d)
  );

  // S4: normalise so the hidden bit sits at XW-1, round to nearest even, range check.
  always_comb begin
    if (s3_sum_q[SW-1]) begin
      norm = {s3_sum_q[SW-1:2], |s3_sum_q[1:0]};
      e_n  = {2'b00, s3_exp_q} + EW'(1);
    end else begin
      norm = s3_sum_q[XW-1:0] << (s3_lz_q - CW'(1));
      e_n  = {2'b00, s3_exp_q} - EW'(s3_lz_q) + EW'(1);
    end
    rnd   = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(norm[2] & (norm[1] | norm[0] | norm[3]));
    e_r   = rnd[MAN_W+1] ? e_n + EW'(1) : e_n;
    man_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    result_d        = {s3_sign_q, EXP_W'(e_r), man_r};
    flags_d         = '0;
    flags_d[FLG_NX] = |norm[2:0];
    if (s3_spc_q[W+1]) begin
      result_d         = s3_spc_q[W-1:0];
      flags_d          = '0;
      flags_d[FLG_INV] = s3_spc_q[W];
    end else if (s3_sum_q == '0) begin
      result_d = {s3_sign_q & ~s3_sub_q, {(W-1){1'b0}}};
      flags_d  = '0;
    end else if (e_r <= 0) begin
      result_d         = {s3_sign_q, {(W-1){1'b0}}};
      flags_d[FLG_UNF] = 1'b1;
      flags_d[FLG_NX]  = 1'b1;
    end else if (e_r >= EMAX) begin
      result_d         = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLG_OVF] = 1'b1;
      flags_d[FLG_NX]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (adv) begin
      v_q <= {v_q[2:0], in_valid};
      if (v_q[2]) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q  <= s1_sign_d;   s1_sub_q   <= s1_sub_d;   s1_exp_q <= s1_exp_d;
      s1_diff_q  <= s1_diff_d;   s1_man_l_q <= s1_man_l_d; s1_man_s_q <= s1_man_s_d;
      s1_spc_q   <= s1_spc_d;
      s2_sign_q  <= s1_sign_q;   s2_sub_q   <= s1_sub_q;   s2_exp_q <= s1_exp_q;
      s2_man_l_q <= {s1_man_l_q, 3'b000};
      s2_man_s_q <= s2_man_s_d;  s2_spc_q   <= s1_spc_q;
      s3_sign_q  <= s2_sign_q;   s3_sub_q   <= s2_sub_q;   s3_exp_q <= s2_exp_q;
      s3_sum_q   <= s3_sum_d;    s3_lz_q    <= s3_lz_d;    s3_spc_q <= s2_spc_q;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe (single precision): arithmetic, specials, stall and reset.
module tb_fpu_addsub_pipe;

  logic        clk, reset, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] din1, din2, result;
  logic [3:0]  flags;
  int          n_cmp, n_err;

  fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din2(din2), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] er, input logic [3:0] ef);
    int cnt;
    @(negedge clk);
    din1 = a; din2 = b; op = o; in_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ".lat"}, cnt, 32'd4);
    chk({tag, ".res"}, result, er);
    chk({tag, ".flg"}, 32'(flags), 32'(ef));
  endtask

  logic [31:0] s_a [8];
  logic [31:0] s_e [8];
  logic [31:0] q[$];
  logic [31:0] held, want;
  int          idx, nout, spur;

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; din1 = '0; din2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset.vld", 32'(out_valid), 32'd0);
    chk("reset.res", result, 32'h0);
    chk("reset.flg", 32'(flags), 32'd0);
    chk("reset.rdy", 32'(in_ready), 32'd1);

    run_op("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    run_op("sub_eq",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_op("negzero",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_op("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_op("tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_op("underflow",  32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    run_op("snan",       32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("qnan",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run_op("inf_fin",    32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
    run_op("sub_neg",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    run_op("denorm_ftz", 32'h40000000, 32'h00400000, 1'b0, 32'h40000000, 4'b0000);

    // Back-to-back stream of k+1 plus 1.0 with the consumer stalled on cycles 5..7.
    s_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    s_e = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    idx = 0; nout = 0; held = '0;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        din1 = s_a[idx]; din2 = 32'h3F800000; op = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        chk("stall.rdy", 32'(in_ready), 32'd0);
        chk("stall.vld", 32'(out_valid), 32'd1);
        if (c == 5) held = result;
        else chk("stall.hold", result, held);
      end
      if (out_valid && out_ready) begin
        want = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
        chk("stream.res", result, want);
        chk("stream.flg", 32'(flags), 32'd0);
        nout++;
      end
      if (in_valid && in_ready) begin
        q.push_back(s_e[idx]);
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream.count", nout, 32'd8);
    chk("stream.left", q.size(), 32'd0);

    // Reset while two operations are in flight: nothing may emerge afterwards.
    in_valid = 1'b1; din1 = 32'h3F800000; din2 = 32'h40000000; op = 1'b0;
    @(negedge clk);
    din1 = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.res", result, 32'h0);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    spur = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) spur++;
    end
    chk("rst.spurious", spur, 32'd0);
    run_op("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
